// File: rtl/rgmii_tx_speed_switch_ctrl.sv
// Link-speed switch sequencer for the RGMII TX clock generator: drains the MAC, resets the generator, and waits for it to settle.
// Optional drain timeout is enabled by defining RGMII_SPEED_SW_TIMEOUT_EN.
module rgmii_tx_speed_switch_ctrl #(
    parameter logic [1:0] init_setting_p  = 2'b00,
    parameter int         rst_cycles_p    = 16,
    parameter int         settle_cycles_p = 32,
    parameter int         drain_timeout_p = 4096
) (
    input  logic       clk250_i,
    input  logic       clk250_rst_i,
    input  logic       speed_v_i,
    input  logic [1:0] speed_i,
    output logic       speed_ready_o,
    input  logic       tx_idle_i,
    output logic       tx_hold_o,
    output logic       gen_rst_o,
    output logic [1:0] clk_setting_o,
    output logic       done_o,
    output logic       err_o,
    output logic       timeout_o
);

    localparam int max_rs_c  = (rst_cycles_p > settle_cycles_p) ? rst_cycles_p : settle_cycles_p;
    localparam int cnt_max_c = (max_rs_c > drain_timeout_p) ? max_rs_c : drain_timeout_p;
    localparam int cnt_w_c   = $clog2(cnt_max_c + 1);

    localparam logic [cnt_w_c-1:0] rst_load_c    = cnt_w_c'(rst_cycles_p - 1);
    localparam logic [cnt_w_c-1:0] settle_load_c = cnt_w_c'(settle_cycles_p - 1);
    localparam logic [cnt_w_c-1:0] drain_load_c  = cnt_w_c'(drain_timeout_p - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        RESET  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t             state_reg;
    logic [cnt_w_c-1:0] cnt_reg;
    logic [1:0]         pend_reg;
    logic               load_reg;   // counter not yet loaded since the async reset
    logic               por_reg;    // current sequence is the power-on one: no done pulse
    logic               drain_timeout;

`ifdef RGMII_SPEED_SW_TIMEOUT_EN
    assign drain_timeout = (state_reg == DRAIN) && (cnt_reg == '0) && !tx_idle_i;

    always_ff @(posedge clk250_i or posedge clk250_rst_i) begin
        if (clk250_rst_i) begin
            timeout_o <= 1'b0;
        end else if (drain_timeout) begin
            timeout_o <= 1'b1;
        end
    end
`else
    assign drain_timeout = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    always_ff @(posedge clk250_i or posedge clk250_rst_i) begin
        if (clk250_rst_i) begin
            state_reg     <= RESET;
            cnt_reg       <= '0;
            pend_reg      <= init_setting_p;
            load_reg      <= 1'b1;
            por_reg       <= 1'b1;
            clk_setting_o <= init_setting_p;
            gen_rst_o     <= 1'b1;
            tx_hold_o     <= 1'b1;
            speed_ready_o <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (speed_v_i && speed_ready_o) begin
                        if (speed_i == 2'b11) begin
                            err_o  <= 1'b1;
                            done_o <= 1'b1;
                        end else if (speed_i == clk_setting_o) begin
                            done_o <= 1'b1;
                        end else begin
                            pend_reg      <= speed_i;
                            state_reg     <= DRAIN;
                            tx_hold_o     <= 1'b1;
                            speed_ready_o <= 1'b0;
                            cnt_reg       <= drain_load_c;
                        end
                    end
                end
                DRAIN: begin
                    // Setting is applied on the same edge the generator enters reset.
                    if (tx_idle_i || drain_timeout) begin
                        state_reg     <= RESET;
                        gen_rst_o     <= 1'b1;
                        clk_setting_o <= pend_reg;
                        cnt_reg       <= rst_load_c;
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESET: begin
                    if (load_reg) begin
                        load_reg <= 1'b0;
                        cnt_reg  <= rst_load_c;
                    end else if (cnt_reg == '0) begin
                        state_reg <= SETTLE;
                        gen_rst_o <= 1'b0;
                        cnt_reg   <= settle_load_c;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= IDLE;
                        tx_hold_o     <= 1'b0;
                        speed_ready_o <= 1'b1;
                        done_o        <= !por_reg;
                        por_reg       <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_tx_speed_switch_ctrl.sv
// Randomized bench for rgmii_tx_speed_switch_ctrl; expected sequence lengths come from a transaction-level model.
`timescale 1ns/100ps
module tb_rgmii_tx_speed_switch_ctrl;

    localparam logic [1:0] INIT = 2'b00;
    localparam int RST_N = 16;
    localparam int SET_N = 32;
    localparam int DT    = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       speed_v = 1'b0;
    logic [1:0] speed = 2'b00;
    logic       tx_idle = 1'b1;
    logic       speed_ready, tx_hold, gen_rst, done, err, timeout;
    logic [1:0] clk_setting;

    int vec_cnt = 0;
    int err_cnt = 0;
    int bad_change = 0;
    logic [1:0] prev_setting = INIT;

    logic [1:0] m_setting = INIT;
    logic       m_err = 1'b0;
    logic       m_timeout = 1'b0;
`ifdef RGMII_SPEED_SW_TIMEOUT_EN
    bit timeout_en = 1'b1;
`else
    bit timeout_en = 1'b0;
`endif

    rgmii_tx_speed_switch_ctrl #(
        .init_setting_p (INIT),
        .rst_cycles_p   (RST_N),
        .settle_cycles_p(SET_N),
        .drain_timeout_p(DT)
    ) dut (
        .clk250_i     (clk),
        .clk250_rst_i (rst),
        .speed_v_i    (speed_v),
        .speed_i      (speed),
        .speed_ready_o(speed_ready),
        .tx_idle_i    (tx_idle),
        .tx_hold_o    (tx_hold),
        .gen_rst_o    (gen_rst),
        .clk_setting_o(clk_setting),
        .done_o       (done),
        .err_o        (err),
        .timeout_o    (timeout)
    );

    always #2 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; sample #1 after the edge and watch for setting changes outside generator reset.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst && clk_setting !== prev_setting && gen_rst !== 1'b1) bad_change++;
        prev_setting = clk_setting;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_gen_rst"}, gen_rst, 1);
        check_val({tag, "_hold"}, tx_hold, 1);
        check_val({tag, "_ready"}, speed_ready, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_timeout"}, timeout, 0);
        check_val({tag, "_setting"}, clk_setting, INIT);
    endtask

    // After reset release: generator reset RST_N cycles, settle SET_N cycles, then idle with no done pulse.
    task automatic por_check(input string tag);
        int hi = 0, st = 0, dn = 0, badset = 0;
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) dn++;
            if (gen_rst) begin
                hi++;
                if (clk_setting !== INIT) badset++;
            end else if (tx_hold) begin
                st++;
            end else begin
                ok = 1;
                break;
            end
        end
        check_val({tag, "_reached_idle"}, ok, 1);
        check_val({tag, "_rst_cycles"}, hi, RST_N);
        check_val({tag, "_settle_cycles"}, st, SET_N);
        check_val({tag, "_done_pulses"}, dn, 0);
        check_val({tag, "_badset"}, badset, 0);
        check_val({tag, "_ready"}, speed_ready, 1);
        check_val({tag, "_err"}, err, m_err);
        $display("txn power-on: rst=%0d settle=%0d done=%0d", hi, st, dn);
    endtask

    // Issue one request; tx_idle rises d cycles after the accept.
    task automatic do_req(input logic [1:0] s, input int d);
        int drain = 1, hi = 0, st = 0, dn = 0, badset = 0, badrdy = 0, odd = 0;
        int exp_drain;
        bit seen_rst = 0, finished = 0;
        check_val("pre_ready", speed_ready, 1);
        speed_v = 1'b1;
        speed   = s;
        tx_idle = (d == 0);
        tick();
        speed_v = 1'b0;
        if (s == 2'b11 || s == m_setting) begin
            if (s == 2'b11) m_err = 1'b1;
            check_val("nochg_done", done, 1);
            check_val("nochg_gen_rst", gen_rst, 0);
            check_val("nochg_hold", tx_hold, 0);
            check_val("nochg_setting", clk_setting, m_setting);
            check_val("nochg_err", err, m_err);
            tx_idle = 1'b1;
            tick();
            check_val("nochg_done_end", done, 0);
            $display("txn req=%b no-switch err=%b setting=%b", s, err, clk_setting);
            return;
        end
        check_val("drain_hold", tx_hold, 1);
        check_val("drain_ready", speed_ready, 0);
        check_val("drain_done", done, 0);
        for (int k = 1; k < 20000; k++) begin
            tick();
            if (done) begin
                finished = 1;
                break;
            end
            if (gen_rst) begin
                hi++;
                seen_rst = 1;
                if (clk_setting !== s) badset++;
            end else if (tx_hold) begin
                if (seen_rst) st++;
                else drain++;
            end else begin
                odd++;
            end
            if (speed_ready) badrdy++;
            if (seen_rst) tx_idle = 1'($urandom_range(0, 1));
            else tx_idle = (k >= d);
            speed_v = 1'($urandom_range(0, 1));
            speed   = 2'($urandom_range(0, 3));
        end
        speed_v = 1'b0;
        tx_idle = 1'b1;
        exp_drain = d + 1;
        if (timeout_en && d >= DT) begin
            exp_drain = DT;
            m_timeout = 1'b1;
        end
        m_setting = s;
        check_val("sw_finished", finished, 1);
        check_val("sw_drain_cycles", drain, exp_drain);
        check_val("sw_rst_cycles", hi, RST_N);
        check_val("sw_settle_cycles", st, SET_N);
        check_val("sw_badset", badset, 0);
        check_val("sw_badrdy", badrdy, 0);
        check_val("sw_odd", odd, 0);
        check_val("sw_ready", speed_ready, 1);
        check_val("sw_hold", tx_hold, 0);
        check_val("sw_setting", clk_setting, m_setting);
        check_val("sw_err", err, m_err);
        check_val("sw_timeout", timeout, m_timeout);
        tick();
        check_val("sw_done_end", done, 0);
        $display("txn req=%b delay=%0d drain=%0d rst=%0d settle=%0d", s, d, drain, hi, st);
    endtask

    initial begin
        int found, st;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        por_check("por");

        do_req(2'b00, 0);
        check_val("same_gen_rst", gen_rst, 0);
        do_req(2'b01, 0);
        do_req(2'b00, 3);
        do_req(2'b11, 0);
        do_req(2'b10, 100);
        do_req(2'b00, 0);

        // Abort a 00->10 switch partway through SETTLE.
        speed_v = 1'b1;
        speed   = 2'b10;
        tx_idle = 1'b1;
        tick();
        speed_v = 1'b0;
        found = 0;
        st = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (gen_rst) found = 1;
            else if (found && tx_hold) st++;
            if (st == 10) break;
        end
        check_val("abort_reached_settle", st, 10);
        check_val("abort_setting_before", clk_setting, 2'b10);
        #0.5;
        rst = 1'b1;
        #0.5;
        check_reset_vals("abort");
        m_setting = INIT;
        m_err = 1'b0;
        m_timeout = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        por_check("abort_por");

        for (int n = 0; n < 12; n++) begin
            int d;
            d = ($urandom_range(0, 4) == 0) ? 60 : int'($urandom_range(0, 8));
            do_req(2'($urandom_range(0, 3)), d);
            repeat ($urandom_range(0, 4)) begin
                tx_idle = 1'($urandom_range(0, 1));
                tick();
                check_val("idle_done", done, 0);
                check_val("idle_hold", tx_hold, 0);
            end
            tx_idle = 1'b1;
        end

        check_val("setting_change_outside_rst", bad_change, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
